wb_sram_responder: RTL and testbench
====================================

# wb_sram_responder

Wishbone responder (peripheral end) backing a single-port word-organised SRAM, with byte-lane writes, programmable wait states and address-range error reporting. Sits on the data-side Wishbone bus behind the CPU's aligned-only data membus initiator and serves its word-aligned, byte-selected reads and writes. It is also used as scratchpad RAM in SoC builds.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, ≥ 2.
- BASE_ADDR, 32'h1000_0000: byte base address; aligned to DEPTH_WORDS*4.
- WAIT_STATES, 0: extra cycles (0–15) inserted before the response.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- wb  Wishbone.Peripheral  —  interface with the following signals.
  - wb.cyc, wb.stb  (in, 1)  request valid when both are high.
  - wb.we  (in, 1)  1 = write.
  - wb.addr  (in, 32)  byte address; bits [1:0] are ignored.
  - wb.sel  (in, 4)  byte-lane enables; bit n selects byte [8n+7:8n].
  - wb.data_wr  (in, 32)  write data, already lane-aligned.
  - wb.data_rd  (out, 32)  read data.
  - wb.ack  (out, 1)  one-cycle success response.
  - wb.err  (out, 1)  one-cycle error response.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if cyc&stb, latch addr, we, sel and data_wr. Go to WAIT if WAIT_STATES>0, else RESP.
- WAIT: a counter counts down from WAIT_STATES-1. Go to RESP when the count is 0.
- RESP: exactly one of ack or err is high for one cycle. Always return to IDLE.
- Range check: in range iff BASE_ADDR ≤ addr < BASE_ADDR + 4*DEPTH_WORDS.
  - Out of range: err=1, ack=0, memory unchanged, data_rd unchanged.
- Word index = (addr - BASE_ADDR) >> 2, width log2(DEPTH_WORDS).
- Write: commit only selected bytes, on the edge that enters RESP. Unselected bytes keep their old value.
- Read: data_rd is loaded with the full 32-bit word (all lanes, independent of sel) on the edge that enters RESP. It holds that value until the next successful read. The initiator extracts and extends lanes itself.
- Abort: if cyc or stb drops while in WAIT, go to IDLE. No ack, no err, no write.
- In RESP the request lines are ignored. The initiator still holds stb during the ack cycle; this must not start a second transaction.
- Back-to-back: when stb is high in the IDLE cycle after RESP, it is a new request, because the initiator reissues stb on the ack edge.

## Timing
- Reset values: ack=0, err=0, data_rd=0, state IDLE, wait counter 0. Memory contents are not reset.
- Reset during WAIT or RESP: next cycle is IDLE with ack/err low. A pending write is dropped.
- Cycle 0 is the first cycle with cyc&stb in IDLE. ack/err are high in cycle 1+WAIT_STATES, and are low in every other cycle.
- Throughput: one transaction per 2+WAIT_STATES cycles.
- ack and err are never high in the same cycle.

## Configuration
- WB_SRAM_SEL_CHECK_EN defined: an in-range request whose sel is not one of the patterns below returns err with no write:
  - 0001, 0010, 0100, 1000 (byte)
  - 0011, 1100 (halfword)
  - 1111 (word)
- WB_SRAM_SEL_CHECK_EN defined: this includes sel=0000 and patterns such as 0110 or 0101.
- WB_SRAM_SEL_CHECK_EN undefined: any sel is accepted. sel=0000 acks without writing; a read still returns the full word.

## Test plan
- Write 32'hDEADBEEF, sel 1111, to 32'h1000_0010, then read it back → ack in cycle 1 each time (WAIT_STATES=0); read data_rd=32'hDEADBEEF.
- Byte write 32'h0000_5A00 with sel 0010 to the same word, then read → data_rd=32'hDEAD5AEF.
- WAIT_STATES=3: a read issued in cycle 0 → ack high only in cycle 4. Drop stb in cycle 2 of another request → no ack/err, memory unchanged.
- Access 32'h1000_1000 (one past the end) and 32'h0FFF_FFFC → err one cycle, ack low. A following read of 32'h1000_0010 still returns 32'hDEAD5AEF.
- Back-to-back: keep stb high, reissuing a new address on the ack edge → two acks spaced two cycles apart, each with correct data. No duplicate ack for the held stb.
- With WB_SRAM_SEL_CHECK_EN, a write with sel 0110 → err, word unchanged. Without it → ack, and bytes 1–2 are written.

Source files
------------

// File: rtl/wb_sram_responder_if.sv
// Wishbone bus bundle used by the data-side SRAM responder.
interface Wishbone;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        ack;
    logic        err;

    modport Peripheral (
        input  cyc, stb, we, addr, sel, data_wr,
        output data_rd, ack, err
    );

    modport Initiator (
        output cyc, stb, we, addr, sel, data_wr,
        input  data_rd, ack, err
    );
endinterface

// File: rtl/wb_sram_responder.sv
// Wishbone responder over a word-organised SRAM with byte lanes, wait states and range errors.
// Optional macro WB_SRAM_SEL_CHECK_EN: reject sel patterns that are not byte/halfword/word.
module wb_sram_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    Wishbone.Peripheral  wb
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + (33'(DEPTH_WORDS) * 33'd4);
    localparam logic [CNT_W-1:0] WAIT_INIT =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               req_we;
    logic [3:0]         req_sel;
    logic [31:0]        req_data;
    logic [IDX_W-1:0]   req_idx;
    logic               req_ok;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               req_c;
    logic [31:0]        offset_c;
    logic               in_range_c;
    logic               sel_ok_c;
    logic               live_ok_c;
    logic [IDX_W-1:0]   live_idx_c;
    logic               cur_we_c;
    logic [3:0]         cur_sel_c;
    logic [31:0]        cur_data_c;
    logic [IDX_W-1:0]   cur_idx_c;
    logic               cur_ok_c;
    logic               enter_resp_c;
    logic               commit_wr_c;
    logic               commit_rd_c;
    logic               unused_c;

    assign req_c      = wb.cyc & wb.stb;
    assign offset_c   = wb.addr - BASE_ADDR;
    assign in_range_c = ({1'b0, wb.addr} >= {1'b0, BASE_ADDR}) && ({1'b0, wb.addr} < END_ADDR);
    assign live_idx_c = offset_c[IDX_W+1:2];
    assign unused_c   = ^{wb.addr[1:0], offset_c};

    // Lane-pattern qualification for an in-range request
`ifdef WB_SRAM_SEL_CHECK_EN
    always_comb begin
        sel_ok_c = 1'b0;
        case (wb.sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: sel_ok_c = 1'b1;
            default:                   sel_ok_c = 1'b0;
        endcase
    end
`else
    assign sel_ok_c = 1'b1;
`endif

    assign live_ok_c = in_range_c & sel_ok_c;

    // With zero wait states the request commits on the same edge it is seen
    assign cur_we_c   = (state == IDLE) ? wb.we      : req_we;
    assign cur_sel_c  = (state == IDLE) ? wb.sel     : req_sel;
    assign cur_data_c = (state == IDLE) ? wb.data_wr : req_data;
    assign cur_idx_c  = (state == IDLE) ? live_idx_c : req_idx;
    assign cur_ok_c   = (state == IDLE) ? live_ok_c  : req_ok;

    always_comb begin
        enter_resp_c = 1'b0;
        case (state)
            IDLE:    enter_resp_c = req_c && (WAIT_STATES == 0);
            WAIT:    enter_resp_c = req_c && (wait_cnt == '0);
            default: enter_resp_c = 1'b0;
        endcase
    end

    assign commit_wr_c = enter_resp_c & cur_ok_c &  cur_we_c & ~i_rst;
    assign commit_rd_c = enter_resp_c & cur_ok_c & ~cur_we_c;

    // Control FSM with registered responses and read data
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            req_we     <= 1'b0;
            req_sel    <= '0;
            req_data   <= '0;
            req_idx    <= '0;
            req_ok     <= 1'b0;
            wb.ack     <= 1'b0;
            wb.err     <= 1'b0;
            wb.data_rd <= '0;
        end else begin
            wb.ack <= 1'b0;
            wb.err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_c) begin
                        req_we   <= wb.we;
                        req_sel  <= wb.sel;
                        req_data <= wb.data_wr;
                        req_idx  <= live_idx_c;
                        req_ok   <= live_ok_c;
                        wait_cnt <= WAIT_INIT;
                        state    <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!req_c) begin
                        state <= IDLE;
                    end else if (wait_cnt == '0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_resp_c) begin
                wb.ack <= cur_ok_c;
                wb.err <= ~cur_ok_c;
            end
            if (commit_rd_c) begin
                wb.data_rd <= mem[cur_idx_c];
            end
        end
    end

    // Byte-lane write port; contents are not reset
    always_ff @(posedge i_clk) begin
        if (commit_wr_c) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_sel_c[b]) begin
                    mem[cur_idx_c][8*b +: 8] <= cur_data_c[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_responder.sv
// Directed self-checking bench for wb_sram_responder: zero and three wait-state instances.
module tb_wb_sram_responder;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    Wishbone wb0 ();
    Wishbone wb3 ();

    wb_sram_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1000_0000), .WAIT_STATES(0)) dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .wb    (wb0)
    );

    wb_sram_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1000_0000), .WAIT_STATES(3)) dut3 (
        .i_clk (clk),
        .i_rst (rst),
        .wb    (wb3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int b, input logic v, input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] d);
        if (b == 0) begin
            wb0.cyc = v; wb0.stb = v; wb0.we = we; wb0.addr = addr; wb0.sel = sel; wb0.data_wr = d;
        end else begin
            wb3.cyc = v; wb3.stb = v; wb3.we = we; wb3.addr = addr; wb3.sel = sel; wb3.data_wr = d;
        end
    endtask

    task automatic sample(input int b, output logic a, output logic e, output logic [31:0] d);
        if (b == 0) begin
            a = wb0.ack; e = wb0.err; d = wb0.data_rd;
        end else begin
            a = wb3.ack; e = wb3.err; d = wb3.data_rd;
        end
    endtask

    // One transaction: cycle 0 is the first cycle with the request presented.
    // abort_at >= 0 drops the request for that cycle onwards.
    task automatic xfer(input int b, input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdata, input int abort_at,
                        output int resp_cyc, output int n_ack, output int n_err,
                        output logic [31:0] rdata);
        logic a, e;
        logic [31:0] d;
        bit dropped = 0;
        @(posedge clk); #1;
        drive(b, 1'b1, we, addr, sel, wdata);
        resp_cyc = -1; n_ack = 0; n_err = 0; rdata = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            sample(b, a, e, d);
            if (a) n_ack++;
            if (e) n_err++;
            if ((a || e) && resp_cyc < 0) begin
                resp_cyc = c;
                rdata    = d;
            end
            if (resp_cyc < 0) rdata = d;
            @(posedge clk); #1;
            if (!dropped && (resp_cyc >= 0 || c + 1 == abort_at)) begin
                drive(b, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
                dropped = 1;
            end
        end
        if (!dropped) drive(b, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    int          rc, na, ne;
    logic [31:0] rd;
    int          ack_c0, ack_c1, acks;
    logic [31:0] d0, d1;

    initial begin
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack0", 32'(wb0.ack), 32'd0);
        check("rst_err0", 32'(wb0.err), 32'd0);
        check("rst_data0", wb0.data_rd, 32'h0);
        check("rst_data3", wb3.data_rd, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full word write and read back
        xfer(0, 1'b1, 32'h1000_0010, 4'b1111, 32'hDEAD_BEEF, -1, rc, na, ne, rd);
        check("wr_word_cyc", 32'(rc), 32'd1);
        check("wr_word_nack", 32'(na), 32'd1);
        check("wr_word_nerr", 32'(ne), 32'd0);
        xfer(0, 1'b0, 32'h1000_0010, 4'b1111, 32'h0, -1, rc, na, ne, rd);
        check("rd_word_cyc", 32'(rc), 32'd1);
        check("rd_word_nack", 32'(na), 32'd1);
        check("rd_word_data", rd, 32'hDEAD_BEEF);

        // Single byte lane 1
        xfer(0, 1'b1, 32'h1000_0010, 4'b0010, 32'h0000_5A00, -1, rc, na, ne, rd);
        check("wr_byte_nack", 32'(na), 32'd1);
        xfer(0, 1'b0, 32'h1000_0010, 4'b0001, 32'h0, -1, rc, na, ne, rd);
        check("rd_byte_data", rd, 32'hDEAD_5AEF);

        // Out-of-range accesses on both sides of the window
        xfer(0, 1'b0, 32'h1000_1000, 4'b1111, 32'h0, -1, rc, na, ne, rd);
        check("oor_hi_cyc", 32'(rc), 32'd1);
        check("oor_hi_nerr", 32'(ne), 32'd1);
        check("oor_hi_nack", 32'(na), 32'd0);
        check("oor_hi_data_held", rd, 32'hDEAD_5AEF);
        xfer(0, 1'b1, 32'h0FFF_FFFC, 4'b1111, 32'h1234_0000, -1, rc, na, ne, rd);
        check("oor_lo_nerr", 32'(ne), 32'd1);
        check("oor_lo_nack", 32'(na), 32'd0);
        xfer(0, 1'b0, 32'h1000_0010, 4'b1111, 32'h0, -1, rc, na, ne, rd);
        check("after_oor_data", rd, 32'hDEAD_5AEF);

        // Last valid word is in range
        xfer(0, 1'b1, 32'h1000_0FFC, 4'b1111, 32'h0BAD_F00D, -1, rc, na, ne, rd);
        check("last_word_nack", 32'(na), 32'd1);
        xfer(0, 1'b1, 32'h1000_0020, 4'b1111, 32'h1234_5678, -1, rc, na, ne, rd);
        check("wr_b_nack", 32'(na), 32'd1);

        // Back-to-back reads: stb held through ack, new address reissued on the ack edge
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h1000_0010, 4'b1111, 32'h0);
        ack_c0 = -1; ack_c1 = -1; acks = 0; d0 = '0; d1 = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (wb0.ack) begin
                acks++;
                if (ack_c0 < 0) begin ack_c0 = c; d0 = wb0.data_rd; end
                else if (ack_c1 < 0) begin ack_c1 = c; d1 = wb0.data_rd; end
            end
            @(posedge clk); #1;
            if (wb0.ack && ack_c1 < 0) drive(0, 1'b1, 1'b0, 32'h1000_0020, 4'b1111, 32'h0);
            else if (ack_c1 >= 0) drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("b2b_ack0_cyc", 32'(ack_c0), 32'd1);
        check("b2b_ack1_cyc", 32'(ack_c1), 32'd3);
        check("b2b_nack", 32'(acks), 32'd2);
        check("b2b_data0", d0, 32'hDEAD_5AEF);
        check("b2b_data1", d1, 32'h1234_5678);

        // Non-contiguous lanes and empty sel
        xfer(0, 1'b1, 32'h1000_0010, 4'b0110, 32'hAABB_CCDD, -1, rc, na, ne, rd);
`ifdef WB_SRAM_SEL_CHECK_EN
        check("sel0110_nerr", 32'(ne), 32'd1);
        check("sel0110_nack", 32'(na), 32'd0);
        xfer(0, 1'b0, 32'h1000_0010, 4'b1111, 32'h0, -1, rc, na, ne, rd);
        check("sel0110_data", rd, 32'hDEAD_5AEF);
`else
        check("sel0110_nack", 32'(na), 32'd1);
        check("sel0110_nerr", 32'(ne), 32'd0);
        xfer(0, 1'b0, 32'h1000_0010, 4'b1111, 32'h0, -1, rc, na, ne, rd);
        check("sel0110_data", rd, 32'hDEBB_CCEF);
`endif
        xfer(0, 1'b1, 32'h1000_0020, 4'b0000, 32'hFFFF_FFFF, -1, rc, na, ne, rd);
`ifdef WB_SRAM_SEL_CHECK_EN
        check("sel0000_nerr", 32'(ne), 32'd1);
`else
        check("sel0000_nack", 32'(na), 32'd1);
`endif
        xfer(0, 1'b0, 32'h1000_0020, 4'b0000, 32'h0, -1, rc, na, ne, rd);
`ifdef WB_SRAM_SEL_CHECK_EN
        check("sel0000_rd_nerr", 32'(ne), 32'd1);
`else
        check("sel0000_rd_data", rd, 32'h1234_5678);
`endif

        // Three wait states
        xfer(3, 1'b1, 32'h1000_0040, 4'b1111, 32'hCAFE_F00D, -1, rc, na, ne, rd);
        check("ws3_wr_cyc", 32'(rc), 32'd4);
        check("ws3_wr_nack", 32'(na), 32'd1);
        xfer(3, 1'b0, 32'h1000_0040, 4'b1111, 32'h0, -1, rc, na, ne, rd);
        check("ws3_rd_cyc", 32'(rc), 32'd4);
        check("ws3_rd_nack", 32'(na), 32'd1);
        check("ws3_rd_data", rd, 32'hCAFE_F00D);
        xfer(3, 1'b1, 32'h1000_0040, 4'b1111, 32'h1111_1111, 2, rc, na, ne, rd);
        check("ws3_abort_nack", 32'(na), 32'd0);
        check("ws3_abort_nerr", 32'(ne), 32'd0);
        xfer(3, 1'b0, 32'h1000_0040, 4'b1111, 32'h0, -1, rc, na, ne, rd);
        check("ws3_abort_data", rd, 32'hCAFE_F00D);
        xfer(3, 1'b0, 32'h1000_1000, 4'b1111, 32'h0, -1, rc, na, ne, rd);
        check("ws3_oor_cyc", 32'(rc), 32'd4);
        check("ws3_oor_nerr", 32'(ne), 32'd1);

        // Reset during WAIT drops the pending write
        @(posedge clk); #1;
        drive(3, 1'b1, 1'b1, 32'h1000_0040, 4'b1111, 32'h7777_7777);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(3, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (wb3.ack || wb3.err) acks++;
        end
        check("rst_wait_resp", 32'(acks), 32'd0);
        check("rst_wait_data", wb3.data_rd, 32'h0);
        xfer(3, 1'b0, 32'h1000_0040, 4'b1111, 32'h0, -1, rc, na, ne, rd);
        check("rst_wait_mem", rd, 32'hCAFE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Response exclusivity on both instances for the whole run
    always @(negedge clk) begin
        if (!rst && ((wb0.ack && wb0.err) || (wb3.ack && wb3.err))) begin
            check("ack_err_excl", 32'd1, 32'd0);
        end
    end

endmodule
